mips_mc_ctrl: RTL and testbench

Multicycle control unit for the single-issue MIPS core: accepts one instruction word at a time, decodes it, and sequences the datapath through execute, memory and writeback. It is the producer side of the ALU interface, driving the 5-bit ALU opcode and shift amount that the ALU consumes. It also drives register-file, data-memory and PC-update strobes.

---
 rtl/mips_mc_ctrl_pkg.sv | 69 ++++++
 rtl/mips_mc_ctrl_if.sv | 33 +++
 rtl/mips_mc_ctrl_decode.sv | 86 ++++++++
 rtl/mips_mc_ctrl.sv | 113 +++++++++++
 tb/tb_mips_mc_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: ALU opcodes, MIPS
// opcode/funct fields, FSM states, PC-source selects and instruction classes.
package mips_ctrl_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_NOP  = 5'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_REG = 2'd3
  } pc_src_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_NOP, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JR
  } iclass_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [4:0] shamt;
    logic       src_imm;
    logic       zext;
    logic       reg_dst;
    logic       mem_to_reg;
    iclass_e    cls;
  } dec_t;

  localparam dec_t DEC_RESET = '{alu_op: ALU_NOP, shamt: 5'd0, src_imm: 1'b0,
                                 zext: 1'b0, reg_dst: 1'b0, mem_to_reg: 1'b0,
                                 cls: CLS_NOP};

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/fetch/memory signal bundle. The master modport is the
// controller; the slave modport is the surrounding datapath.
interface mips_mc_ctrl_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        alu_zero;
  logic        mem_ready;
  logic [4:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_src_imm;
  logic        imm_zext;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        illegal;

  modport master (
    input  instr_valid, instr, alu_zero, mem_ready,
    output instr_ready, alu_op, alu_shamt, alu_src_imm, imm_zext, reg_dst,
           mem_to_reg, reg_write, mem_read, mem_write, pc_write, pc_src, illegal
  );

  modport slave (
    output instr_valid, instr, alu_zero, mem_ready,
    input  instr_ready, alu_op, alu_shamt, alu_src_imm, imm_zext, reg_dst,
           mem_to_reg, reg_write, mem_read, mem_write, pc_write, pc_src, illegal
  );
endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational instruction decoder: IR -> ALU controls, instruction class and
// an illegal flag. The all-zero word decodes as nop rather than sll.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output dec_t        o_dec,
  output logic        o_illegal
);

  always_comb begin
    o_dec = '{alu_op: ALU_NOP, shamt: i_ir[10:6], src_imm: 1'b0, zext: 1'b0,
              reg_dst: 1'b0, mem_to_reg: 1'b0, cls: CLS_ALU};
    o_illegal = 1'b0;
    case (i_ir[31:26])
      OP_RTYPE: begin
        o_dec.reg_dst = 1'b1;
        if (i_ir == '0) begin
          o_dec.cls = CLS_NOP;
        end else begin
          case (i_ir[5:0])
            FN_ADD:  o_dec.alu_op = ALU_ADD;
            FN_ADDU: o_dec.alu_op = ALU_ADDU;
            FN_SUB:  o_dec.alu_op = ALU_SUB;
            FN_SUBU: o_dec.alu_op = ALU_SUBU;
            FN_AND:  o_dec.alu_op = ALU_AND;
            FN_OR:   o_dec.alu_op = ALU_OR;
            FN_NOR:  o_dec.alu_op = ALU_NOR;
            FN_SLT:  o_dec.alu_op = ALU_SLT;
            FN_SLL:  o_dec.alu_op = ALU_SLL;
            FN_SRL:  o_dec.alu_op = ALU_SRL;
            FN_SRA:  o_dec.alu_op = ALU_SRA;
            FN_JR: begin
              o_dec.alu_op = ALU_JR;
              o_dec.cls    = CLS_JR;
            end
            default: o_illegal = 1'b1;
          endcase
        end
      end
      OP_ADDI: begin
        o_dec.alu_op  = ALU_ADD;
        o_dec.src_imm = 1'b1;
      end
      OP_ADDIU: begin
        o_dec.alu_op  = ALU_ADDU;
        o_dec.src_imm = 1'b1;
      end
      OP_SLTI: begin
        o_dec.alu_op  = ALU_SLT;
        o_dec.src_imm = 1'b1;
      end
      OP_ANDI: begin
        o_dec.alu_op  = ALU_AND;
        o_dec.src_imm = 1'b1;
        o_dec.zext    = 1'b1;
      end
      OP_ORI: begin
        o_dec.alu_op  = ALU_OR;
        o_dec.src_imm = 1'b1;
        o_dec.zext    = 1'b1;
      end
      OP_LW: begin
        o_dec.alu_op     = ALU_ADDU;
        o_dec.src_imm    = 1'b1;
        o_dec.mem_to_reg = 1'b1;
        o_dec.cls        = CLS_LW;
      end
      OP_SW: begin
        o_dec.alu_op  = ALU_ADDU;
        o_dec.src_imm = 1'b1;
        o_dec.cls     = CLS_SW;
      end
      OP_BEQ: begin
        o_dec.alu_op = ALU_SUBU;
        o_dec.cls    = CLS_BEQ;
      end
      OP_J: begin
        o_dec.alu_op = ALU_NOP;
        o_dec.cls    = CLS_J;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB). Decoded fields are
// registered on DECODE exit; strobes are decoded from state and latched class.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mips_mc_ctrl_if.master bus
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_ir;
  dec_t        r_dec;
  dec_t        w_dec;
  logic        w_illegal;
  logic        r_illegal;
  logic        w_take;

  assign w_take = (r_state == ST_IDLE) && bus.instr_valid;

  mips_ctrl_decode u_decode (
    .i_ir      (r_ir),
    .o_dec     (w_dec),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Illegal is registered off DECODE so it lands as a one-cycle pulse in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_dec     <= DEC_RESET;
      r_illegal <= 1'b0;
    end else begin
      if (w_take) r_ir <= bus.instr;
      if (r_state == ST_DECODE) r_dec <= w_dec;
      r_illegal <= (r_state == ST_DECODE) && w_illegal;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.instr_valid) w_next = ST_DECODE;
      ST_DECODE: w_next = w_illegal ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        case (r_dec.cls)
          CLS_ALU, CLS_NOP: w_next = ST_WB;
          CLS_LW, CLS_SW:   w_next = ST_MEM;
          default:          w_next = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) w_next = (r_dec.cls == CLS_LW) ? ST_WB : ST_IDLE;
      end
      ST_WB:     w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = PC_SEQ;
    case (r_state)
      ST_IDLE: bus.instr_ready = 1'b1;
      ST_EXEC: begin
        case (r_dec.cls)
          CLS_BEQ: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.alu_zero ? PC_BRANCH : PC_SEQ;
          end
          CLS_J: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_JUMP;
          end
          CLS_JR: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_REG;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.mem_read  = (r_dec.cls == CLS_LW);
        bus.mem_write = (r_dec.cls == CLS_SW);
        bus.pc_write  = (r_dec.cls == CLS_SW) && bus.mem_ready;
      end
      ST_WB: begin
        bus.reg_write = (r_dec.cls != CLS_NOP);
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_op      = r_dec.alu_op;
  assign bus.alu_shamt   = r_dec.shamt;
  assign bus.alu_src_imm = r_dec.src_imm;
  assign bus.imm_zext    = r_dec.zext;
  assign bus.reg_dst     = r_dec.reg_dst;
  assign bus.mem_to_reg  = r_dec.mem_to_reg;
  assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: table-driven instruction model plus a
// per-instruction timeline expectation derived from the cycle latencies.
module tb_mips_mc_ctrl;

  localparam int K_ALU = 0, K_NOP = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                 K_J = 5, K_JR = 6, K_ILL = 7;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         alu;
    bit         imm;
    bit         zx;
    bit         rd;
    bit         m2r;
    int         kind;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;
  row_t tbl[$];

  int obs_pcw_n, obs_pcw_cyc, obs_pcw_src, obs_rw_n, obs_rw_cyc, obs_m2r_rw;
  int obs_mem_n, obs_mem_first, obs_memw_n, obs_ill_n, obs_ill_cyc, obs_ready_cyc;
  int obs_ready_c1;
  logic [4:0] obs_alu, obs_shamt;
  logic [3:0] obs_flags;

  task automatic add_row(input logic [5:0] op, input logic [5:0] fn, input int alu,
                         input bit imm, input bit zx, input bit rd, input bit m2r,
                         input int kind);
    row_t r;
    r.op = op; r.fn = fn; r.alu = alu; r.imm = imm; r.zx = zx; r.rd = rd;
    r.m2r = m2r; r.kind = kind;
    tbl.push_back(r);
  endtask

  function automatic row_t lookup(input logic [31:0] ins);
    row_t r;
    r.op = ins[31:26]; r.fn = ins[5:0]; r.alu = 12; r.imm = 0; r.zx = 0;
    r.rd = 1; r.m2r = 0; r.kind = (ins == 32'd0) ? K_NOP : K_ILL;
    if (ins == 32'd0) return r;
    foreach (tbl[i])
      if (tbl[i].op == ins[31:26] && (tbl[i].op != 6'h00 || tbl[i].fn == ins[5:0]))
        return tbl[i];
    return r;
  endfunction

  function automatic logic [31:0] build(input row_t r);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = r.op;
    if (r.op == 6'h00) w[5:0] = r.fn;
    if (w == 32'd0) w[11] = 1'b1;
    return w;
  endfunction

  function automatic int exp_ready(input int kind, input int w);
    case (kind)
      K_ALU, K_NOP:     return 4;
      K_LW:             return 5 + w;
      K_SW:             return 4 + w;
      K_BEQ, K_J, K_JR: return 3;
      default:          return 2;
    endcase
  endfunction

  // Issues one instruction (handshake = cycle 0) and records the timeline until
  // instr_ready returns. Must be called just after a rising edge, in IDLE.
  task automatic run(input logic [31:0] ins, input bit zero, input int wait_n,
                     input bit hold);
    int memcnt;
    memcnt = 0;
    obs_pcw_n = 0; obs_pcw_cyc = -1; obs_pcw_src = -1; obs_rw_n = 0; obs_rw_cyc = -1;
    obs_m2r_rw = -1; obs_mem_n = 0; obs_mem_first = -1; obs_memw_n = 0;
    obs_ill_n = 0; obs_ill_cyc = -1; obs_ready_cyc = -1; obs_ready_c1 = -1;
    bus.alu_zero = zero; bus.instr = ins; bus.instr_valid = 1'b1;
    bus.mem_ready = 1'($urandom_range(1));
    for (int cyc = 1; cyc <= 40 && obs_ready_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (hold) begin bus.instr_valid = 1'b1; bus.instr = $urandom; end
      else bus.instr_valid = 1'b0;
      if (bus.mem_read || bus.mem_write) begin
        memcnt++;
        bus.mem_ready = (memcnt > wait_n);
      end else bus.mem_ready = 1'($urandom_range(1));
      #1;
      if (bus.pc_write) begin obs_pcw_n++; obs_pcw_cyc = cyc; obs_pcw_src = int'(bus.pc_src); end
      if (bus.reg_write) begin obs_rw_n++; obs_rw_cyc = cyc; obs_m2r_rw = int'(bus.mem_to_reg); end
      if (bus.mem_read) begin obs_mem_n++; if (obs_mem_first < 0) obs_mem_first = cyc; end
      if (bus.mem_write) obs_memw_n++;
      if (bus.illegal) begin obs_ill_n++; obs_ill_cyc = cyc; end
      if (cyc == 1) obs_ready_c1 = int'(bus.instr_ready);
      if (cyc == 2) begin
        obs_alu = bus.alu_op; obs_shamt = bus.alu_shamt;
        obs_flags = {bus.alu_src_imm, bus.imm_zext, bus.reg_dst, bus.mem_to_reg};
      end
      if (bus.instr_ready) begin obs_ready_cyc = cyc; bus.instr_valid = 1'b0; end
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    if (obs_ready_cyc < 0) begin
      vectors++; errors++;
      $display("FAIL timeout ins=%h: instr_ready never returned within 40 cycles", ins);
    end
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0; bus.instr = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.instr_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    vectors++;
    if (bus.alu_op !== 5'd12) begin errors++;
      $display("FAIL reset_alu_op got=%0d exp=12", bus.alu_op); end
    vectors++;
    if ({bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write, bus.pc_src, bus.illegal,
         bus.alu_shamt, bus.alu_src_imm, bus.imm_zext, bus.reg_dst, bus.mem_to_reg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rw=%b mr=%b mw=%b pcw=%b src=%0d ill=%b sh=%0d imm=%b zx=%b rd=%b m2r=%b exp all 0",
               bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write, bus.pc_src, bus.illegal,
               bus.alu_shamt, bus.alu_src_imm, bus.imm_zext, bus.reg_dst, bus.mem_to_reg);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_alu_like(input logic [31:0] ins, input string tag);
    row_t r;
    r = lookup(ins);
    run(ins, 1'($urandom_range(1)), 0, 1'b0);
    vectors++;
    if (obs_alu !== 5'(r.alu) || obs_shamt !== ins[10:6]) begin errors++;
      $display("FAIL %s_fields ins=%h got alu=%0d sh=%0d exp alu=%0d sh=%0d", tag, ins, obs_alu, obs_shamt, r.alu, ins[10:6]); end
    vectors++;
    if (obs_flags !== {r.imm, r.zx, r.rd, r.m2r}) begin errors++;
      $display("FAIL %s_flags ins=%h got=%b exp=%b", tag, ins, obs_flags, {r.imm, r.zx, r.rd, r.m2r}); end
    vectors++;
    if (obs_ready_c1 != 0 || obs_rw_n != 1 || obs_rw_cyc != 3 || obs_pcw_n != 1 || obs_pcw_cyc != 3 ||
        obs_pcw_src != 0 || obs_ready_cyc != 4 || obs_mem_n + obs_memw_n + obs_ill_n != 0) begin errors++;
      $display("FAIL %s_timing ins=%h got rdy1=%0d rw=%0d@%0d pcw=%0d@%0d src=%0d rdy@%0d mem=%0d ill=%0d exp rdy1=0 rw=1@3 pcw=1@3 src=0 rdy@4 mem=0 ill=0",
               tag, ins, obs_ready_c1, obs_rw_n, obs_rw_cyc, obs_pcw_n, obs_pcw_cyc, obs_pcw_src, obs_ready_cyc,
               obs_mem_n + obs_memw_n, obs_ill_n); end
  endtask

  task automatic test_alu();
    row_t alu_rows[$];
    check_alu_like(32'h00221820, "add");
    check_alu_like(32'h00031143, "sra");
    foreach (tbl[i]) if (tbl[i].kind == K_ALU) alu_rows.push_back(tbl[i]);
    for (int n = 0; n < 24; n++)
      check_alu_like(build(alu_rows[$urandom_range(alu_rows.size() - 1)]), "alu_rand");
  endtask

  task automatic test_nop();
    run(32'd0, 1'b0, 0, 1'b0);
    vectors++;
    if (obs_alu !== 5'd12 || obs_rw_n != 0 || obs_pcw_n != 1 || obs_pcw_cyc != 3 ||
        obs_pcw_src != 0 || obs_ready_cyc != 4) begin errors++;
      $display("FAIL nop got alu=%0d rw=%0d pcw=%0d@%0d src=%0d rdy@%0d exp alu=12 rw=0 pcw=1@3 src=0 rdy@4",
               obs_alu, obs_rw_n, obs_pcw_n, obs_pcw_cyc, obs_pcw_src, obs_ready_cyc); end
  endtask

  task automatic check_mem(input logic [31:0] ins, input int w);
    bit is_lw;
    is_lw = (ins[31:26] == 6'h23);
    run(ins, 1'($urandom_range(1)), w, 1'b0);
    vectors++;
    if (obs_alu !== 5'd1 || obs_flags[3] !== 1'b1 || obs_flags[0] !== is_lw) begin errors++;
      $display("FAIL mem_fields ins=%h got alu=%0d flags=%b exp alu=1 imm=1 m2r=%0d", ins, obs_alu, obs_flags, is_lw); end
    vectors++;
    if (is_lw) begin
      if (obs_mem_n != w + 1 || obs_mem_first != 3 || obs_rw_n != 1 || obs_rw_cyc != 4 + w ||
          obs_m2r_rw != 1 || obs_pcw_n != 1 || obs_pcw_cyc != 4 + w || obs_pcw_src != 0 ||
          obs_ready_cyc != 5 + w || obs_memw_n != 0) begin errors++;
        $display("FAIL lw_timing ins=%h w=%0d got mr=%0d@%0d rw=%0d@%0d m2r=%0d pcw=%0d@%0d src=%0d rdy@%0d mw=%0d exp mr=%0d@3 rw=1@%0d m2r=1 pcw=1@%0d src=0 rdy@%0d mw=0",
                 ins, w, obs_mem_n, obs_mem_first, obs_rw_n, obs_rw_cyc, obs_m2r_rw, obs_pcw_n, obs_pcw_cyc,
                 obs_pcw_src, obs_ready_cyc, obs_memw_n, w + 1, 4 + w, 4 + w, 5 + w); end
    end else begin
      if (obs_memw_n != w + 1 || obs_mem_n != 0 || obs_rw_n != 0 || obs_pcw_n != 1 ||
          obs_pcw_cyc != 3 + w || obs_pcw_src != 0 || obs_ready_cyc != 4 + w) begin errors++;
        $display("FAIL sw_timing ins=%h w=%0d got mw=%0d mr=%0d rw=%0d pcw=%0d@%0d src=%0d rdy@%0d exp mw=%0d mr=0 rw=0 pcw=1@%0d src=0 rdy@%0d",
                 ins, w, obs_memw_n, obs_mem_n, obs_rw_n, obs_pcw_n, obs_pcw_cyc, obs_pcw_src, obs_ready_cyc,
                 w + 1, 3 + w, 4 + w); end
    end
  endtask

  task automatic test_mem();
    check_mem(32'h8C240008, 3);
    for (int n = 0; n < 10; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[31:26] = (n % 2 == 0) ? 6'h23 : 6'h2B;
      check_mem(w, $urandom_range(4));
    end
  endtask

  task automatic check_flow(input logic [31:0] ins, input bit zero, input int exp_src,
                            input int exp_alu, input string tag);
    run(ins, zero, 0, 1'b0);
    vectors++;
    if (obs_alu !== 5'(exp_alu) || obs_pcw_n != 1 || obs_pcw_cyc != 2 || obs_pcw_src != exp_src ||
        obs_rw_n != 0 || obs_ready_cyc != 3 || obs_mem_n + obs_memw_n != 0) begin errors++;
      $display("FAIL %s ins=%h z=%0d got alu=%0d pcw=%0d@%0d src=%0d rw=%0d rdy@%0d exp alu=%0d pcw=1@2 src=%0d rw=0 rdy@3",
               tag, ins, zero, obs_alu, obs_pcw_n, obs_pcw_cyc, obs_pcw_src, obs_rw_n, obs_ready_cyc,
               exp_alu, exp_src); end
  endtask

  task automatic test_branch();
    check_flow(32'h10220004, 1'b1, 1, 3, "beq_taken");
    check_flow(32'h10220004, 1'b0, 0, 3, "beq_not_taken");
    check_flow(32'h08000010, 1'b1, 2, 12, "j");
    check_flow(32'h03E00008, 1'b0, 3, 11, "jr");
    for (int n = 0; n < 6; n++) begin
      logic [31:0] w;
      bit z;
      w = $urandom; w[31:26] = 6'h04; z = 1'($urandom_range(1));
      check_flow(w, z, z ? 1 : 0, 3, "beq_rand");
    end
  endtask

  task automatic check_illegal(input logic [31:0] ins);
    run(ins, 1'b0, 0, 1'b0);
    vectors++;
    if (obs_ill_n != 1 || obs_ill_cyc != 2 || obs_pcw_n != 0 || obs_rw_n != 0 ||
        obs_mem_n + obs_memw_n != 0 || obs_ready_cyc != 2) begin errors++;
      $display("FAIL illegal ins=%h got ill=%0d@%0d pcw=%0d rw=%0d mem=%0d rdy@%0d exp ill=1@2 pcw=0 rw=0 mem=0 rdy@2",
               ins, obs_ill_n, obs_ill_cyc, obs_pcw_n, obs_rw_n, obs_mem_n + obs_memw_n, obs_ready_cyc); end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    check_illegal(32'hFC000000);
    check_illegal(32'h00221821 ^ 32'h00000010);
    for (int n = 0; n < 8; n++) begin
      w = $urandom;
      for (int k = 0; k < 100 && lookup(w).kind != K_ILL; k++) w = $urandom;
      check_illegal(w);
    end
  endtask

  task automatic test_back_to_back();
    row_t r;
    logic [31:0] w;
    for (int n = 0; n < 8; n++) begin
      r = tbl[$urandom_range(tbl.size() - 1)];
      w = build(r);
      run(w, 1'b1, 0, 1'b1);
      vectors++;
      if (obs_alu !== 5'(r.alu) || obs_shamt !== w[10:6] || obs_flags !== {r.imm, r.zx, r.rd, r.m2r} ||
          obs_pcw_n != 1 || obs_ready_cyc != exp_ready(r.kind, 0)) begin errors++;
        $display("FAIL back_to_back ins=%h got alu=%0d sh=%0d flags=%b pcw=%0d rdy@%0d exp alu=%0d sh=%0d flags=%b pcw=1 rdy@%0d",
                 w, obs_alu, obs_shamt, obs_flags, obs_pcw_n, obs_ready_cyc, r.alu, w[10:6],
                 {r.imm, r.zx, r.rd, r.m2r}, exp_ready(r.kind, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad;
    bus.instr = 32'h8C240008; bus.instr_valid = 1'b1; bus.mem_ready = 1'b0; bus.alu_zero = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    while (bus.mem_read !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (bus.mem_read !== 1'b1) begin errors++;
      $display("FAIL reset_mid_reach_mem got mem_read=%b exp=1 within 10 cycles", bus.mem_read); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.instr_ready !== 1'b1 || bus.alu_op !== 5'd12 || bus.mem_read !== 1'b0 ||
        bus.pc_write !== 1'b0 || bus.reg_write !== 1'b0 || bus.mem_to_reg !== 1'b0 ||
        bus.alu_src_imm !== 1'b0) begin errors++;
      $display("FAIL reset_mid_async got rdy=%b alu=%0d mr=%b pcw=%b rw=%b m2r=%b imm=%b exp rdy=1 alu=12 others 0",
               bus.instr_ready, bus.alu_op, bus.mem_read, bus.pc_write, bus.reg_write,
               bus.mem_to_reg, bus.alu_src_imm); end
    @(posedge clk); #3 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (bus.pc_write || bus.reg_write || bus.mem_read) bad++;
    end
    vectors++;
    if (bad != 0 || bus.instr_ready !== 1'b1) begin errors++;
      $display("FAIL reset_mid_quiet got strobe_cycles=%0d rdy=%b exp strobe_cycles=0 rdy=1", bad, bus.instr_ready); end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    add_row(6'h00, 6'h20, 0, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h21, 1, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h22, 2, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h23, 3, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h24, 4, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h25, 5, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h27, 6, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h2A, 7, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h00, 8, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h02, 9, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h03, 10, 0, 0, 1, 0, K_ALU);
    add_row(6'h00, 6'h08, 11, 0, 0, 1, 0, K_JR);
    add_row(6'h08, 6'h00, 0, 1, 0, 0, 0, K_ALU);
    add_row(6'h09, 6'h00, 1, 1, 0, 0, 0, K_ALU);
    add_row(6'h0A, 6'h00, 7, 1, 0, 0, 0, K_ALU);
    add_row(6'h0C, 6'h00, 4, 1, 1, 0, 0, K_ALU);
    add_row(6'h0D, 6'h00, 5, 1, 1, 0, 0, K_ALU);
    add_row(6'h23, 6'h00, 1, 1, 0, 0, 1, K_LW);
    add_row(6'h2B, 6'h00, 1, 1, 0, 0, 0, K_SW);
    add_row(6'h04, 6'h00, 3, 0, 0, 0, 0, K_BEQ);
    add_row(6'h02, 6'h00, 12, 0, 0, 0, 0, K_J);

    test_reset();
    test_alu();
    test_nop();
    test_mem();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
